// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: control-bundle field layout, per-boundary
// data widths and the MAIN entry update selector used by pipe_stage_buf.
package pipe_pkg;

   localparam int unsigned CTRL_W_DEF   = 8;

   // Control-bundle field offsets (bit positions inside ctrl)
   localparam int unsigned CTRL_WREG    = 0;
   localparam int unsigned CTRL_WMEM    = 1;
   localparam int unsigned CTRL_M2REG   = 2;
   localparam int unsigned CTRL_M2REG_W = 2;
   localparam int unsigned CTRL_MFHI    = 4;
   localparam int unsigned CTRL_MFLO    = 5;
   localparam int unsigned CTRL_RN      = 6;
   localparam int unsigned CTRL_RN_W    = 2;

   // Data-bundle widths per stage boundary
   localparam int unsigned IF_ID_DATA_W  = 64;
   localparam int unsigned ID_EX_DATA_W  = 96;
   localparam int unsigned EX_MEM_DATA_W = 64;
   localparam int unsigned MEM_WB_DATA_W = 64;

   typedef enum logic [1:0] {
      MAIN_HOLD,
      MAIN_FROM_IN,
      MAIN_FROM_SKID,
      MAIN_CLEAR
   } main_op_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline holding entry: valid + ctrl + data with load, clear and async reset.
// An invalid entry always holds ctrl = 0 so a bubble propagates as a NOP.
module pipe_entry_reg #(
   parameter int unsigned CTRL_W     = 8,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned CLEAR_DATA = 0
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (clear) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
         if (CLEAR_DATA != 0) data_d = '0;
      end else if (load) begin
         valid_d = 1'b1;
         ctrl_d  = d_ctrl;
         data_d  = d_data;
      end
   end

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign ctrl  = ctrl_q;
   assign data  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with valid/ready handshake, synchronous flush
// and optional 2-entry skid buffer giving a registered in_ready.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W     = EX_MEM_DATA_W,
   parameter int unsigned CTRL_W     = CTRL_W_DEF,
   parameter int unsigned SKID       = 1,
   parameter int unsigned CLEAR_DATA = 0
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              main_v, skid_v;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ld_ctrl;
   logic [DATA_W-1:0] main_data, skid_data, main_ld_data;
   logic              accept, emit;
   logic              skid_load, skid_clear;
   main_op_e          main_op;

   // One decision tree serves both modes: with SKID=0 an accept always finds
   // MAIN free or emitting, so the skid-load branch is never taken.
   always_comb begin
      accept     = in_valid && in_ready;
      emit       = main_v && out_ready;
      main_op    = MAIN_HOLD;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      if (flush) begin
         main_op    = MAIN_CLEAR;
         skid_clear = 1'b1;
      end else if (emit && skid_v) begin
         main_op    = MAIN_FROM_SKID;
         skid_clear = 1'b1;
      end else if (accept && (!main_v || out_ready)) begin
         main_op    = MAIN_FROM_IN;
      end else if (accept) begin
         skid_load  = 1'b1;
      end else if (emit) begin
         main_op    = MAIN_CLEAR;
      end
   end

   assign main_ld_ctrl = (main_op == MAIN_FROM_SKID) ? skid_ctrl : in_ctrl;
   assign main_ld_data = (main_op == MAIN_FROM_SKID) ? skid_data : in_data;

   pipe_entry_reg #(
      .CTRL_W     (CTRL_W),
      .DATA_W     (DATA_W),
      .CLEAR_DATA (CLEAR_DATA)
   ) u_main (
      .clk    (clk),
      .clrn   (clrn),
      .load   ((main_op == MAIN_FROM_IN) || (main_op == MAIN_FROM_SKID)),
      .clear  (main_op == MAIN_CLEAR),
      .d_ctrl (main_ld_ctrl),
      .d_data (main_ld_data),
      .valid  (main_v),
      .ctrl   (main_ctrl),
      .data   (main_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         pipe_entry_reg #(
            .CTRL_W     (CTRL_W),
            .DATA_W     (DATA_W),
            .CLEAR_DATA (CLEAR_DATA)
         ) u_skid (
            .clk    (clk),
            .clrn   (clrn),
            .load   (skid_load),
            .clear  (skid_clear),
            .d_ctrl (in_ctrl),
            .d_data (in_data),
            .valid  (skid_v),
            .ctrl   (skid_ctrl),
            .data   (skid_data)
         );
         assign in_ready = !skid_v;
      end else begin : g_noskid
         assign skid_v    = 1'b0;
         assign skid_ctrl = '0;
         assign skid_data = '0;
         assign in_ready  = !main_v || out_ready;
      end
   endgenerate

   assign out_valid = main_v;
   assign out_ctrl  = main_ctrl;
   assign out_data  = main_data;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed + random bench for pipe_stage_buf: instance A (SKID=1, CLEAR_DATA=0)
// and instance B (SKID=0, CLEAR_DATA=1), each checked against a FIFO scoreboard.
module tb_pipe_stage_buf;

   typedef struct packed {
      logic [7:0]  ctrl;
      logic [63:0] data;
   } beat_t;

   logic        clk = 1'b0;
   logic        clrn;

   logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [7:0]  a_in_ctrl, a_out_ctrl;
   logic [63:0] a_in_data, a_out_data;
   logic [1:0]  a_occ;

   logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [7:0]  b_in_ctrl, b_out_ctrl;
   logic [63:0] b_in_data, b_out_data;
   logic [1:0]  b_occ;

   beat_t qa[$];
   beat_t qb[$];
   int    tests = 0;
   int    fails = 0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CLEAR_DATA(0)) dut_a (
      .clk(clk), .clrn(clrn), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
      .occupancy(a_occ)
   );

   pipe_stage_buf #(.DATA_W(64), .CTRL_W(8), .SKID(0), .CLEAR_DATA(1)) dut_b (
      .clk(clk), .clrn(clrn), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
      .occupancy(b_occ)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle on A, check at the falling edge, update the scoreboard.
   task automatic step_a(input logic v, input logic [7:0] c, input logic [63:0] d,
                         input logic rdy, input logic fl, output logic acc);
      logic exp_v, exp_rdy;
      beat_t b;
      a_in_valid = v; a_in_ctrl = c; a_in_data = d; a_out_ready = rdy; a_flush = fl;
      @(negedge clk);
      exp_v   = (qa.size() != 0);
      exp_rdy = (qa.size() < 2);
      chk("a_out_valid", {63'd0, a_out_valid}, {63'd0, exp_v});
      chk("a_in_ready",  {63'd0, a_in_ready},  {63'd0, exp_rdy});
      chk("a_occupancy", {62'd0, a_occ},       64'(qa.size()));
      if (exp_v) begin
         chk("a_out_data", a_out_data, qa[0].data);
         chk("a_out_ctrl", {56'd0, a_out_ctrl}, {56'd0, qa[0].ctrl});
      end else begin
         chk("a_bubble_ctrl", {56'd0, a_out_ctrl}, 64'd0);
      end
      acc = v && exp_rdy;
      if (exp_v && rdy) void'(qa.pop_front());
      if (fl) qa.delete();
      else if (acc) begin
         b.ctrl = c; b.data = d;
         qa.push_back(b);
      end
      @(posedge clk); #1;
   endtask

   task automatic step_b(input logic v, input logic [7:0] c, input logic [63:0] d,
                         input logic rdy);
      logic exp_v, exp_rdy;
      beat_t b;
      b_in_valid = v; b_in_ctrl = c; b_in_data = d; b_out_ready = rdy; b_flush = 1'b0;
      @(negedge clk);
      exp_v   = (qb.size() != 0);
      exp_rdy = !exp_v || rdy;
      chk("b_out_valid", {63'd0, b_out_valid}, {63'd0, exp_v});
      chk("b_in_ready",  {63'd0, b_in_ready},  {63'd0, exp_rdy});
      chk("b_in_ready_rule", {63'd0, b_in_ready}, {63'd0, (!b_out_valid || rdy)});
      chk("b_occupancy", {62'd0, b_occ}, 64'(qb.size()));
      if (exp_v) begin
         chk("b_out_data", b_out_data, qb[0].data);
         chk("b_out_ctrl", {56'd0, b_out_ctrl}, {56'd0, qb[0].ctrl});
      end else begin
         chk("b_bubble_ctrl", {56'd0, b_out_ctrl}, 64'd0);
      end
      if (exp_v && rdy) void'(qb.pop_front());
      if (v && exp_rdy) begin
         b.ctrl = c; b.data = d;
         qb.push_back(b);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic        acc;
      logic [63:0] abc[3];
      int          k;

      clrn = 1'b1;
      a_flush = 1'b0; a_in_valid = 1'b0; a_in_ctrl = '0; a_in_data = '0; a_out_ready = 1'b0;
      b_flush = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 1'b0;
      #12;
      chk("rst_a_out_valid", {63'd0, a_out_valid}, 64'd0);
      chk("rst_a_out_ctrl",  {56'd0, a_out_ctrl},  64'd0);
      chk("rst_a_out_data",  a_out_data,           64'd0);
      chk("rst_a_occ",       {62'd0, a_occ},       64'd0);
      chk("rst_a_in_ready",  {63'd0, a_in_ready},  64'd1);
      chk("rst_b_out_valid", {63'd0, b_out_valid}, 64'd0);
      chk("rst_b_in_ready",  {63'd0, b_in_ready},  64'd1);
      chk("rst_b_occ",       {62'd0, b_occ},       64'd0);
      @(negedge clk); clrn = 1'b0;
      @(posedge clk); #1;

      // Streaming 0x1..0x10 back-to-back
      for (int i = 1; i <= 16; i++) step_a(1'b1, 8'(i), 64'(i), 1'b1, 1'b0, acc);
      step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, acc);
      step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, acc);

      // Stall for 3 cycles while offering 0xA, 0xB, 0xC
      abc[0] = 64'hA; abc[1] = 64'hB; abc[2] = 64'hC;
      k = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (k < 3) begin
            step_a(1'b1, 8'(k + 1), abc[k], (cyc >= 3), 1'b0, acc);
            if (acc) k++;
         end else begin
            step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, acc);
         end
      end
      chk("stall_all_accepted", 64'(k), 64'd3);

      // Flush with occupancy 2 and a beat offered in the same cycle
      step_a(1'b1, 8'h11, 64'h11, 1'b0, 1'b0, acc);
      step_a(1'b1, 8'h22, 64'h22, 1'b0, 1'b0, acc);
      step_a(1'b1, 8'hFF, 64'hDEAD, 1'b0, 1'b1, acc);
      for (int i = 0; i < 3; i++) step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, acc);

      // Bubble: control cleared, data held (CLEAR_DATA=0)
      step_a(1'b1, 8'h3C, 64'h55, 1'b1, 1'b0, acc);
      step_a(1'b0, 8'hFF, 64'h99, 1'b1, 1'b0, acc);
      chk("bubble_a_valid", {63'd0, a_out_valid}, 64'd0);
      chk("bubble_a_ctrl",  {56'd0, a_out_ctrl},  64'd0);
      chk("bubble_a_data",  a_out_data,           64'h55);

      // Asynchronous reset with both entries full
      step_a(1'b1, 8'h44, 64'h44, 1'b0, 1'b0, acc);
      step_a(1'b1, 8'h45, 64'h45, 1'b0, 1'b0, acc);
      chk("pre_rst_occ", {62'd0, a_occ}, 64'd2);
      a_in_valid = 1'b0;
      clrn = 1'b1;
      #1;
      chk("mid_rst_out_valid", {63'd0, a_out_valid}, 64'd0);
      chk("mid_rst_out_ctrl",  {56'd0, a_out_ctrl},  64'd0);
      chk("mid_rst_occ",       {62'd0, a_occ},       64'd0);
      chk("mid_rst_in_ready",  {63'd0, a_in_ready},  64'd1);
      qa.delete();
      qb.delete();
      @(negedge clk); clrn = 1'b0;
      @(posedge clk); #1;
      step_a(1'b1, 8'h81, 64'h81, 1'b1, 1'b0, acc);
      step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, acc);
      step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, acc);

      // Bubble on B: data cleared (CLEAR_DATA=1)
      step_b(1'b1, 8'h3C, 64'h77, 1'b1);
      step_b(1'b0, 8'hFF, 64'h99, 1'b1);
      chk("bubble_b_ctrl", {56'd0, b_out_ctrl}, 64'd0);
      chk("bubble_b_data", b_out_data, 64'd0);

      // Random handshake on B
      for (int i = 0; i < 10000; i++)
         step_b(1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 2; i++) step_b(1'b0, 8'h00, 64'h0, 1'b1);
      chk("b_scoreboard_empty", 64'(qb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
